decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake bundle for decode_stage.
// The slave side is the decode stage; the master side is its environment.
interface decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic        out_funct7_b5;
   logic [3:0]  out_rd;
   logic        out_uses_rs1;
   logic        out_uses_rs2;
   logic        out_writes_rd;
   logic        out_illegal;
   logic [3:0]  read_loc_1;
   logic [3:0]  read_loc_2;
   logic        wb_valid;
   logic [3:0]  wb_loc;
   logic        flush;

   modport master (
      output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_loc, flush,
      input  in_ready, out_valid, out_pc, out_imm, out_opcode, out_funct3,
             out_funct7_b5, out_rd, out_uses_rs1, out_uses_rs2, out_writes_rd,
             out_illegal, read_loc_1, read_loc_2
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_loc, flush,
      output in_ready, out_valid, out_pc, out_imm, out_opcode, out_funct3,
             out_funct7_b5, out_rd, out_uses_rs1, out_uses_rs2, out_writes_rd,
             out_illegal, read_loc_1, read_loc_2
   );
endinterface

// File: rtl/decode_stage.sv
// RV32E decode stage: single-entry output register with a 16-entry pending-write
// scoreboard that stalls fetch on RAW/WAW hazards until writeback retires.
module decode_stage (
   input  logic          clock,
   input  logic          reset,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic logic signed [31:0] imm_gen(input logic [31:0] ins);
      logic signed [31:0] imm;
      case (ins[6:0])
         OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
         OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
         OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                  imm = '0;
      endcase
      return imm;
   endfunction

   logic [6:0]  opc;
   logic [4:0]  rs1_f, rs2_f, rd_f;
   logic        fmt_rs1, fmt_rs2, fmt_rd, known;
   logic        illegal_c, dec_rs1, dec_rs2, dec_rd;
   logic        hazard, in_ready_c, accept;

   logic               out_valid_q;
   logic [31:0]        pc_q;
   logic signed [31:0] imm_q;
   logic [6:0]         opcode_q;
   logic [2:0]         funct3_q;
   logic               f7b5_q;
   logic [3:0]         rd_q;
   logic               uses_rs1_q, uses_rs2_q, writes_rd_q, illegal_q;
   logic [3:0]         rloc1_q, rloc2_q;
   logic [15:0]        pending_q, pending_d;

   assign opc   = bus.in_instr[6:0];
   assign rd_f  = bus.in_instr[11:7];
   assign rs1_f = bus.in_instr[19:15];
   assign rs2_f = bus.in_instr[24:20];

   always_comb begin
      fmt_rs1 = 1'b0;
      fmt_rs2 = 1'b0;
      fmt_rd  = 1'b0;
      known   = 1'b1;
      case (opc)
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            fmt_rs1 = 1'b1;
            fmt_rd  = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            fmt_rs1 = 1'b1;
            fmt_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC, OP_JAL: fmt_rd = 1'b1;
         OP_REG: begin
            fmt_rs1 = 1'b1;
            fmt_rs2 = 1'b1;
            fmt_rd  = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   // RV32E has only x0-x15, so any referenced field with bit 4 set is illegal.
   assign illegal_c = !known || (opc[1:0] != 2'b11) ||
                      (fmt_rs1 && rs1_f[4]) || (fmt_rs2 && rs2_f[4]) || (fmt_rd && rd_f[4]);
   assign dec_rs1 = fmt_rs1 && !illegal_c;
   assign dec_rs2 = fmt_rs2 && !illegal_c;
   assign dec_rd  = fmt_rd && !illegal_c && (rd_f != 5'd0);

   // Uses registered pending only: a writeback in this cycle unblocks next cycle.
   assign hazard = bus.in_valid && ((dec_rs1 && pending_q[rs1_f[3:0]]) ||
                                    (dec_rs2 && pending_q[rs2_f[3:0]]) ||
                                    (dec_rd  && pending_q[rd_f[3:0]]));

   assign in_ready_c = !reset && (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
   assign accept     = bus.in_valid && in_ready_c;

   always_comb begin
      pending_d = pending_q;
      if (bus.wb_valid) pending_d[bus.wb_loc] = 1'b0;
      if (bus.flush && out_valid_q && writes_rd_q) pending_d[rd_q] = 1'b0;
      if (accept && dec_rd) pending_d[rd_f[3:0]] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         opcode_q    <= '0;
         funct3_q    <= '0;
         f7b5_q      <= 1'b0;
         rd_q        <= '0;
         uses_rs1_q  <= 1'b0;
         uses_rs2_q  <= 1'b0;
         writes_rd_q <= 1'b0;
         illegal_q   <= 1'b0;
         rloc1_q     <= '0;
         rloc2_q     <= '0;
         pending_q   <= '0;
      end else begin
         pending_q <= pending_d;
         if (bus.flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q <= 1'b1;
            pc_q        <= bus.in_pc;
            imm_q       <= imm_gen(bus.in_instr);
            opcode_q    <= opc;
            funct3_q    <= bus.in_instr[14:12];
            f7b5_q      <= bus.in_instr[30];
            rd_q        <= rd_f[3:0];
            uses_rs1_q  <= dec_rs1;
            uses_rs2_q  <= dec_rs2;
            writes_rd_q <= dec_rd;
            illegal_q   <= illegal_c;
            rloc1_q     <= rs1_f[3:0];
            rloc2_q     <= rs2_f[3:0];
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_pc        = pc_q;
   assign bus.out_imm       = imm_q;
   assign bus.out_opcode    = opcode_q;
   assign bus.out_funct3    = funct3_q;
   assign bus.out_funct7_b5 = f7b5_q;
   assign bus.out_rd        = rd_q;
   assign bus.out_uses_rs1  = uses_rs1_q;
   assign bus.out_uses_rs2  = uses_rs2_q;
   assign bus.out_writes_rd = writes_rd_q;
   assign bus.out_illegal   = illegal_q;
   assign bus.read_loc_1    = rloc1_q;
   assign bus.read_loc_2    = rloc2_q;
endmodule
